// File: rtl/frame_writer.sv
// frame_writer: queues camera pixels in a small FIFO and issues one SDRAM write at a time.
// Optional saturating drop counter is built when FRAME_WRITER_DROP_CNT_EN is defined.
module frame_writer #(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic [19:0] write_addr,
  output logic [15:0] write_pixel,
  output logic        start_write,
  input  logic        write_done,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H + 1) : 1;
  localparam int EW = 36;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [19:0]   idx_q, idx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          outstanding_q, outstanding_d;
  logic          start_q, start_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   pix_q, pix_d;
  logic          overflow_q, overflow_d;

  logic [EW-1:0] mem [FIFO_DEPTH];

  logic fifo_empty, fifo_full, pop, restart, take, push, drop, last_pix, x_wrap, launch;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = write_done && outstanding_q;
  assign restart    = frame_start && (state_q != DRAIN);
  // A frame_start cycle never takes a pixel, even when it restarts an active capture.
  assign take       = (state_q == CAPTURE) && pix_valid && !frame_start;
  assign push       = take && (!fifo_full || pop);
  assign drop       = take && !push;
  assign x_wrap     = (x_q == XW'(FRAME_W - 1));
  assign last_pix   = x_wrap && (y_q == YW'(FRAME_H - 1));
  assign launch     = !fifo_empty && !outstanding_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = CAPTURE;
      CAPTURE: if (take && last_pix) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !outstanding_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d    = CAPTURE;
      x_d        = '0;
      y_d        = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
    end else if (take) begin
      idx_d = idx_q + 20'd1;
      if (x_wrap) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    if (drop) overflow_d = 1'b1;
  end

  // Write channel: the head entry stays in the FIFO until its acknowledge arrives.
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    start_d       = launch;
    outstanding_d = outstanding_q;
    addr_d        = addr_q;
    pix_d         = pix_q;
    if (launch) begin
      outstanding_d   = 1'b1;
      {addr_d, pix_d} = mem[rd_ptr_q];
    end else if (pop) begin
      outstanding_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {idx_q, pix_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      idx_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      start_q       <= 1'b0;
      addr_q        <= '0;
      pix_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      idx_q         <= idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      start_q       <= start_d;
      addr_q        <= addr_d;
      pix_q         <= pix_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef FRAME_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (restart) drop_cnt_d = '0;
    else if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

  assign write_addr  = addr_q;
  assign write_pixel = pix_q;
  assign start_write = start_q;
  assign overflow    = overflow_q;
  assign frame_done  = (state_q == DRAIN) && fifo_empty && !outstanding_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on a reduced 20x6 frame: directed vector table, corner sequences,
// and randomized traffic scored against a queue-based model of the frame/FIFO rules.
module tb_frame_writer;

  localparam int W    = 20;
  localparam int H    = 6;
  localparam int D    = 8;
  localparam int NPIX = W * H;

`ifdef FRAME_WRITER_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_valid, write_done;
  logic [15:0] pix_data;
  logic [19:0] write_addr;
  logic [15:0] write_pixel;
  logic        start_write, frame_done, overflow, busy;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  frame_writer #(.FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .write_addr(write_addr), .write_pixel(write_pixel),
    .start_write(start_write), .write_done(write_done), .frame_done(frame_done),
    .overflow(overflow), .busy(busy), .drop_count(drop_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: abstract frame position, FIFO as a queue of pending writes.
  typedef enum int {M_IDLE, M_CAP, M_DRAIN} mstate_t;
  typedef struct {int addr; int data;} ent_t;

  ent_t    q[$];
  mstate_t m_state;
  int      m_x, m_y, m_drops, since, cur_addr, cur_data;
  bit      m_ovf, m_out;
  int      nwrites, fd_count;
  int      wr_log[$];
  int      wd_mode, lat;
  bit      wd_force;

  task automatic model_reset();
    q.delete();
    m_state = M_IDLE;
    m_x = 0; m_y = 0; m_drops = 0; since = 0;
    m_ovf = 0; m_out = 0;
  endtask

  // One clock: choose write_done, drive inputs, advance the model, then score outputs.
  task automatic step(input bit r, input bit fs, input bit pv, input logic [15:0] pd);
    bit   wd, pop, going_idle;
    ent_t e;
    wd = wd_force;
    if (m_out && wd_mode != 0 && since >= lat) wd = 1;
    if (!m_out && wd_mode == 2 && $urandom_range(0, 7) == 0) wd = 1;
    rst = r; frame_start = fs; pix_valid = pv; pix_data = pd; write_done = wd;
    pop        = wd && m_out;
    going_idle = (m_state == M_DRAIN) && (q.size() == 0) && !m_out;
    if (r) begin
      model_reset();
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_out = 0;
      end
      if (fs && m_state != M_DRAIN) begin
        m_state = M_CAP; m_x = 0; m_y = 0; m_ovf = 0; m_drops = 0;
      end else if (m_state == M_CAP && pv) begin
        if (q.size() < D) begin
          e.addr = m_y * W + m_x;
          e.data = int'(pd);
          q.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        if (m_x == W - 1 && m_y == H - 1) m_state = M_DRAIN;
        if (m_x == W - 1) begin m_x = 0; m_y++; end
        else m_x++;
      end else if (going_idle) begin
        m_state = M_IDLE;
      end
    end
    if (m_out) since++;
    @(posedge clk); #1;
    if (start_write) begin
      check("sw_while_outstanding", m_out, 0);
      check("sw_has_entry", q.size() != 0, 1);
      if (q.size() != 0) begin
        check("sw_addr", write_addr, q[0].addr);
        check("sw_data", write_pixel, q[0].data);
      end
      $display("WRITE addr=%0d data=0x%04h", write_addr, write_pixel);
      m_out = 1; since = 0;
      cur_addr = int'(write_addr); cur_data = int'(write_pixel);
      wr_log.push_back(int'(write_addr));
      nwrites++;
    end else if (m_out) begin
      check("hold_addr", write_addr, cur_addr);
      check("hold_data", write_pixel, cur_data);
    end
    if (frame_done) fd_count++;
    check("overflow", overflow, m_ovf);
    check("busy", busy, (m_state != M_IDLE) || (q.size() != 0));
    check("frame_done", frame_done, (m_state == M_DRAIN) && (q.size() == 0) && !m_out);
    check("drop_count", drop_count, DC_EN ? m_drops : 0);
  endtask

  task automatic wait_idle(input int budget, input bit noisy, input string name);
    int n;
    n = 0;
    while (m_state != M_IDLE && n < budget) begin
      if (noisy) step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
      else       step(0, 0, 0, 16'h0000);
      n++;
    end
    check(name, m_state == M_IDLE, 1);
  endtask

  typedef struct {
    bit          r, fs, pv, wd;
    logic [15:0] pd;
    bit          sw, bsy, ovf, fd;
    logic [19:0] addr;
    logic [15:0] pix;
    logic [15:0] dc;
  } vec_t;

  function automatic vec_t mkv(bit r, bit fs, bit pv, bit wd, logic [15:0] pd, bit bsy);
    vec_t v;
    v.r = r; v.fs = fs; v.pv = pv; v.wd = wd; v.pd = pd;
    v.sw = 0; v.bsy = bsy; v.ovf = 0; v.fd = 0; v.addr = '0; v.pix = '0; v.dc = '0;
    return v;
  endfunction

  initial begin
    vec_t tbl[6];
    rst = 1; frame_start = 0; pix_valid = 0; pix_data = '0; write_done = 0;
    model_reset();
    nwrites = 0; fd_count = 0; wd_mode = 1; lat = 1; wd_force = 0;
    @(posedge clk); #1;

    // Reset state, acknowledges and pixels outside a frame, pixel on the frame_start cycle.
    tbl[0] = mkv(1, 0, 0, 0, 16'h0000, 0);
    tbl[1] = mkv(0, 0, 0, 1, 16'h0000, 0);
    tbl[2] = mkv(0, 0, 1, 0, 16'hAAAA, 0);
    tbl[3] = mkv(0, 0, 1, 1, 16'h5555, 0);
    tbl[4] = mkv(0, 1, 1, 0, 16'hBEEF, 1);
    tbl[5] = mkv(1, 0, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].r; frame_start = tbl[i].fs; pix_valid = tbl[i].pv;
      write_done = tbl[i].wd; pix_data = tbl[i].pd;
      @(posedge clk); #1;
      $display("VEC %0d rst=%0b fs=%0b pv=%0b wd=%0b -> sw=%0b busy=%0b ovf=%0b fd=%0b",
               i, tbl[i].r, tbl[i].fs, tbl[i].pv, tbl[i].wd, start_write, busy, overflow, frame_done);
      check("vec_start_write", start_write, tbl[i].sw);
      check("vec_busy", busy, tbl[i].bsy);
      check("vec_overflow", overflow, tbl[i].ovf);
      check("vec_frame_done", frame_done, tbl[i].fd);
      check("vec_write_addr", write_addr, tbl[i].addr);
      check("vec_write_pixel", write_pixel, tbl[i].pix);
      check("vec_drop_count", drop_count, tbl[i].dc);
    end

    // Full frame, data = index, acknowledge one cycle after each request.
    wr_log.delete(); nwrites = 0; fd_count = 0; wd_mode = 1; lat = 1;
    step(0, 1, 0, 16'h0000);
    for (int i = 0; i < NPIX; i++) begin
      step(0, 0, 1, 16'(i));
      repeat (3) step(0, 0, 0, 16'h0000);
    end
    wait_idle(200, 0, "frame_idle_timeout");
    check("frame_writes", nwrites, NPIX);
    check("frame_done_pulses", fd_count, 1);
    check("frame_overflow", overflow, 0);
    check("frame_log_size", wr_log.size(), NPIX);
    if (wr_log.size() == NPIX) begin
      check("addr_line_end", wr_log[W - 1], W - 1);
      check("addr_line_wrap", wr_log[W], W);
      check("addr_last", wr_log[NPIX - 1], NPIX - 1);
    end
    $display("SEQ full_frame writes=%0d frame_done=%0d", nwrites, fd_count);

    // Acknowledge withheld: FIFO fills, later pixels are dropped.
    wd_mode = 0;
    step(0, 1, 0, 16'h0000);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 16'($urandom));
    check("fill_overflow", overflow, 1);
    check("fill_drop_count", drop_count, DC_EN ? 12 : 0);
    check("fill_busy", busy, 1);
    $display("SEQ overflow drop_count=%0d", drop_count);

    // Restart clears the flag; queued writes still drain; restart again after 100 pixels.
    wd_mode = 1; lat = 1;
    step(0, 1, 0, 16'h0000);
    check("restart_overflow", overflow, 0);
    check("restart_drop_count", drop_count, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, 16'(16'h4000 + i));
      repeat (3) step(0, 0, 0, 16'h0000);
    end
    step(0, 1, 0, 16'h0000);
    step(0, 0, 1, 16'hC0DE);
    for (int i = 1; i < NPIX; i++) begin
      step(0, 0, 1, 16'(i));
      repeat (3) step(0, 0, 0, 16'h0000);
    end
    wait_idle(200, 0, "restart_idle_timeout");
    $display("SEQ restart done writes=%0d", nwrites);

    // Reset while a write is outstanding, then a stale acknowledge.
    wd_mode = 0;
    step(0, 1, 0, 16'h0000);
    step(0, 0, 1, 16'h1111);
    step(0, 0, 1, 16'h2222);
    repeat (4) step(0, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0000);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_pixel", write_pixel, 0);
    check("rst_start_write", start_write, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_count", drop_count, 0);
    wd_force = 1;
    step(0, 0, 0, 16'h0000);
    wd_force = 0;
    repeat (3) step(0, 0, 0, 16'h0000);
    check("stale_ack_busy", busy, 0);
    check("stale_ack_start", start_write, 0);
    $display("SEQ reset_mid_write busy=%0b", busy);

    // Randomized frames: pixel rate, ack latency, spurious acks, occasional restarts.
    wd_mode = 2;
    for (int f = 0; f < 5; f++) begin
      int rate, n;
      lat  = $urandom_range(0, 3);
      rate = $urandom_range(1, 4);
      step(0, 1, 0, 16'h0000);
      n = 0;
      while (m_state == M_CAP && n < 3000) begin
        step(0, $urandom_range(0, 399) == 0, $urandom_range(1, rate) == 1, 16'($urandom));
        n++;
      end
      wait_idle(500, 1, "rand_idle_timeout");
      $display("SEQ random frame=%0d lat=%0d rate=1/%0d writes=%0d", f, lat, rate, nwrites);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
